// File: rtl/midi_uart_tx.sv
// midi_uart_tx: buffered 8N1 MIDI serializer for packed 3-byte channel messages
// Ports:
//   clk, reset      clock; synchronous active-high reset
//   midi_in[23:0]   {data2, data1, status} message, qualified by input_valid
//   input_valid     single-cycle push strobe (no backpressure)
//   tx              serial line, idle high, LSB first
//   busy            FIFO non-empty or frame in flight
//   overflow        sticky: a push hit a full FIFO and was dropped
// Build option: MIDI_RUNNING_STATUS_EN suppresses a status byte equal to the last one sent.
module midi_uart_tx #(
  parameter int CLKS_PER_BIT    = 384,
  parameter int FIFO_DEPTH_LOG2 = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] midi_in,
  input  logic        input_valid,
  output logic        tx,
  output logic        busy,
  output logic        overflow
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int AW = FIFO_DEPTH_LOG2;
  localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t r_state, w_state_nxt;
  logic [23:0] r_mem [2**AW];
  logic [AW:0] r_wr, r_rd;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [2:0] r_bit, w_bit_nxt;
  logic [1:0] r_byte, w_byte_nxt;
  logic [23:0] r_msg, w_msg_nxt, w_head;
  logic r_tx, r_ovf, w_empty, w_full, w_push, w_pop, w_term, w_skip, w_tx_nxt;
  assign w_empty = r_wr == r_rd;
  assign w_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_push  = input_valid && !w_full;
  assign w_head  = r_mem[r_rd[AW-1:0]];
  assign w_term  = r_cnt == TERM;
`ifdef MIDI_RUNNING_STATUS_EN
  logic [7:0] r_status;
  logic       r_status_v;
  assign w_skip = r_status_v && (w_head[7:0] == r_status);
  always_ff @(posedge clk)
    if (reset) begin
      r_status_v <= 1'b0;
      r_status   <= '0;
    end else if (w_pop && !w_skip) begin
      r_status_v <= 1'b1;
      r_status   <= w_head[7:0];
    end
`else
  assign w_skip = 1'b0;
`endif
  always_comb begin
    w_pop       = 1'b0;
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    w_bit_nxt   = r_bit;
    w_byte_nxt  = r_byte;
    w_msg_nxt   = r_msg;
    case (r_state)
      IDLE: if (!w_empty) begin
        w_pop       = 1'b1;
        w_state_nxt = START;
      end
      START: begin
        w_cnt_nxt = w_term ? '0 : r_cnt + CW'(1);
        if (w_term) w_state_nxt = DATA;
      end
      DATA: begin
        w_cnt_nxt = w_term ? '0 : r_cnt + CW'(1);
        if (w_term) w_bit_nxt = r_bit + 3'd1;
        if (w_term && r_bit == 3'd7) w_state_nxt = STOP;
      end
      STOP: begin
        w_cnt_nxt = w_term ? '0 : r_cnt + CW'(1);
        if (w_term && r_byte != 2'd2) begin
          w_byte_nxt  = r_byte + 2'd1;
          w_state_nxt = START;
        end else if (w_term) begin
          w_pop       = !w_empty;
          w_state_nxt = w_empty ? IDLE : START;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_pop) begin
      w_msg_nxt  = w_head;
      w_byte_nxt = w_skip ? 2'd1 : 2'd0;
    end
    // tx is registered from next-cycle state so the line changes exactly on bit boundaries
    w_tx_nxt = (w_state_nxt == START) ? 1'b0 :
               (w_state_nxt == DATA)  ? w_msg_nxt[{w_byte_nxt, w_bit_nxt}] : 1'b1;
  end
  always_ff @(posedge clk)
    if (reset) begin
      r_state <= IDLE;
      r_wr    <= '0;
      r_rd    <= '0;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_byte  <= '0;
      r_msg   <= '0;
      r_tx    <= 1'b1;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wr    <= r_wr + (AW+1)'(w_push);
      r_rd    <= r_rd + (AW+1)'(w_pop);
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_byte  <= w_byte_nxt;
      r_msg   <= w_msg_nxt;
      r_tx    <= w_tx_nxt;
      r_ovf   <= r_ovf | (input_valid & w_full);
    end
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr[AW-1:0]] <= midi_in;
  assign tx       = r_tx;
  assign busy     = !w_empty || r_state != IDLE;
  assign overflow = r_ovf;
endmodule

// File: tb/tb_midi_uart_tx.sv
// tb_midi_uart_tx: message-level model of the MIDI transmitter checked every cycle, plus a line decoder
module tb_midi_uart_tx;
  localparam int CPB = 4, DL = 1, DEPTH = 2, MAXC = 4096;
`ifdef MIDI_RUNNING_STATUS_EN
  localparam bit RS = 1'b1;
  localparam int T5_END = 322;
`else
  localparam bit RS = 1'b0;
  localparam int T5_END = 362;
`endif
  logic clk = 1'b0, reset = 1'b1, input_valid = 1'b0;
  logic [23:0] midi_in = '0;
  logic tx, busy, overflow;
  midi_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH_LOG2(DL)) dut (
    .clk(clk), .reset(reset), .midi_in(midi_in), .input_valid(input_valid),
    .tx(tx), .busy(busy), .overflow(overflow)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int checks = 0, failures = 0, n_resets = 0, e_end = 0;
  bit chk_en = 1'b0, rs_v = 1'b0;
  logic [7:0] rs = '0;
  logic exp_tx [MAXC];
  logic exp_busy [MAXC];
  logic exp_ovf [MAXC];
  int pops[$];
  logic [7:0] rx_q[$];
  logic [7:0] exp_rx[$];
  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endfunction
  function automatic void put(int c, logic v);
    if (c < MAXC) exp_tx[c] = v;
  endfunction
  // A message accepted in cycle n starts its start bit at max(n+2, end of previous frame)
  // and is popped the cycle before; FIFO occupancy is the accepted messages not yet popped.
  function automatic void model_push(int n, logic [23:0] m);
    int cnt = 0;
    int start, c;
    bit skip;
    logic [7:0] b;
    foreach (pops[i]) if (pops[i] >= n) cnt++;
    if (cnt >= DEPTH) begin
      for (int k = n + 1; k < MAXC; k++) exp_ovf[k] = 1'b1;
      return;
    end
    skip = RS && rs_v && (m[7:0] == rs);
    if (!skip) begin
      rs = m[7:0];
      rs_v = 1'b1;
    end
    start = (n + 2 > e_end) ? n + 2 : e_end;
    pops.push_back(start - 1);
    c = start;
    for (int bi = skip ? 1 : 0; bi < 3; bi++) begin
      b = m[bi*8 +: 8];
      for (int k = 0; k < CPB; k++) put(c++, 1'b0);
      for (int i = 0; i < 8; i++) for (int k = 0; k < CPB; k++) put(c++, b[i]);
      for (int k = 0; k < CPB; k++) put(c++, 1'b1);
    end
    for (int k = n + 1; k < c && k < MAXC; k++) exp_busy[k] = 1'b1;
    e_end = c;
  endfunction
  function automatic void model_reset(int r);
    for (int c = r + 1; c < MAXC; c++) begin
      exp_tx[c] = 1'b1;
      exp_busy[c] = 1'b0;
      exp_ovf[c] = 1'b0;
    end
    pops.delete();
    e_end = 0;
    rs_v = 1'b0;
    n_resets++;
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic push(logic [23:0] m);
    midi_in = m;
    input_valid = 1'b1;
    model_push(cyc, m);
    step();
    input_valid = 1'b0;
  endtask
  task automatic wait_to(int c);
    while (cyc < c) step();
  endtask
  task automatic do_reset();
    reset = 1'b1;
    model_reset(cyc);
    step();
    reset = 1'b0;
  endtask
  task automatic settle();
    repeat (50) step();
    rx_q.delete();
  endtask
  task automatic check_rx(string name);
    chk({name, "_len"}, rx_q.size(), exp_rx.size());
    foreach (exp_rx[i]) chk(name, (i < rx_q.size()) ? 32'(rx_q[i]) : 32'hxxxxxxxx, 32'(exp_rx[i]));
  endtask
  always @(negedge clk)
    if (chk_en && cyc < MAXC) begin
      chk("tx", tx, exp_tx[cyc]);
      chk("busy", busy, exp_busy[cyc]);
      chk("overflow", overflow, exp_ovf[cyc]);
    end
  logic [7:0] rb;
  int r0;
  initial forever begin
    @(negedge clk);
    if (chk_en && tx === 1'b0) begin
      r0 = n_resets;
      repeat (CPB / 2) @(negedge clk);
      if (r0 == n_resets) chk("start_bit", tx, 1'b0);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        rb[i] = tx;
      end
      repeat (CPB) @(negedge clk);
      if (r0 == n_resets) begin
        chk("stop_bit", tx, 1'b1);
        rx_q.push_back(rb);
      end
    end
  end
  int n, s;
  initial begin
    for (int c = 0; c < MAXC; c++) begin
      exp_tx[c] = 1'b1;
      exp_busy[c] = 1'b0;
      exp_ovf[c] = 1'b0;
    end
    repeat (3) step();
    reset = 1'b0;
    chk_en = 1'b1;
    chk("reset_tx", tx, 1'b1);
    chk("reset_busy", busy, 1'b0);
    chk("reset_ovf", overflow, 1'b0);
    repeat (2) step();
    n = cyc;
    push(24'h403C90);
    chk("t1_busy_n1", busy, 1'b1);
    chk("t1_tx_n1", tx, 1'b1);
    step();
    chk("t1_tx_n2", tx, 1'b0);
    wait_to(n + 121);
    chk("t1_busy_n121", busy, 1'b1);
    step();
    chk("t1_busy_n122", busy, 1'b0);
    exp_rx = '{8'h90, 8'h3C, 8'h40};
    check_rx("t1_rx");
    do_reset();
    settle();
    n = cyc;
    push(24'h403C90);
    push(24'h403E90);
    push(24'h404090);
    push(24'h404190);
    chk("t2_ovf_set", overflow, 1'b1);
    wait_to(n + 367);
    chk("t2_ovf_sticky", overflow, 1'b1);
`ifdef MIDI_RUNNING_STATUS_EN
    exp_rx = '{8'h90, 8'h3C, 8'h40, 8'h3E, 8'h40, 8'h40, 8'h40};
`else
    exp_rx = '{8'h90, 8'h3C, 8'h40, 8'h90, 8'h3E, 8'h40, 8'h90, 8'h40, 8'h40};
`endif
    check_rx("t2_rx");
    do_reset();
    settle();
    n = cyc;
    push(24'h7F2391);
    push(24'h104590);
    push(24'h015A91);
    wait_to(n + 121);
    chk("t3_ovf_before", overflow, 1'b0);
    push(24'h112292);
    chk("t3_ovf_after", overflow, 1'b1);
    wait_to(n + 367);
    exp_rx = '{8'h91, 8'h23, 8'h7F, 8'h90, 8'h45, 8'h10, 8'h91, 8'h5A, 8'h01};
    check_rx("t3_rx");
    chk("t4_ovf_pre", overflow, 1'b1);
    n = cyc;
    push(24'h403C90);
    s = n + 2;
    wait_to(s + 50);
    chk("t4_busy_mid", busy, 1'b1);
    do_reset();
    chk("t4_tx_after", tx, 1'b1);
    chk("t4_busy_after", busy, 1'b0);
    chk("t4_ovf_after", overflow, 1'b0);
    settle();
    n = cyc;
    push(24'h004580);
    wait_to(n + 125);
    exp_rx = '{8'h80, 8'h45, 8'h00};
    check_rx("t4_rx");
    do_reset();
    settle();
    n = cyc;
    push(24'h403C90);
    push(24'h403E90);
    push(24'h003C80);
    wait_to(n + T5_END - 1);
    chk("t5_busy_last", busy, 1'b1);
    step();
    chk("t5_busy_end", busy, 1'b0);
`ifdef MIDI_RUNNING_STATUS_EN
    exp_rx = '{8'h90, 8'h3C, 8'h40, 8'h3E, 8'h40, 8'h80, 8'h3C, 8'h00};
`else
    exp_rx = '{8'h90, 8'h3C, 8'h40, 8'h90, 8'h3E, 8'h40, 8'h80, 8'h3C, 8'h00};
`endif
    check_rx("t5_rx");
    repeat (5) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/midi_uart_tx.md
# midi_uart_tx

Serial MIDI transmitter sitting directly downstream of the MIDI message encoder in the demo. It accepts packed 3-byte MIDI channel messages, buffers them in a small FIFO, and serializes them onto a standard MIDI UART line: 8N1, LSB first, idle high, at a fixed clocks-per-bit rate. The encoder has no backpressure, so overflow is reported rather than stalled.

## Interface
- `CLKS_PER_BIT`, default 384: clk cycles per serial bit (12 MHz / 31250 baud); legal range 2..65535.
- `FIFO_DEPTH_LOG2`, default 2: FIFO holds 2^N messages; legal range 1..4.
- `clk` input 1: clock.
- `reset` input 1: reset, synchronous, active-high.
- `midi_in` input 24: packed message; [7:0] status, [15:8] data1 (note), [23:16] data2 (velocity).
- `input_valid` input 1: single-cycle qualifier for `midi_in`.
- `tx` output 1: serial MIDI out; idle high.
- `busy` output 1: FIFO non-empty or a message is being shifted.
- `overflow` output 1: sticky; a message was dropped because the FIFO was full.

## Operation
- Reset values: `tx`=1, `busy`=0, `overflow`=0. The FIFO is emptied, the state machine goes to IDLE, and the running-status register is invalidated. Reset mid-frame aborts the frame immediately, with `tx` high on the next cycle.
- Push: when `input_valid`=1 and the FIFO is not full, `midi_in` is written at that edge. The full check uses the count before any same-cycle pop. A push to a full FIFO is dropped and sets `overflow`, even if a pop occurs in the same cycle.
- Pop: occurs in IDLE when the FIFO is non-empty. The popped message is latched into a 3-byte shift buffer, and the FIFO slot frees at that edge.
- State machine:
  - IDLE → START on pop.
  - START (tx=0, 1 bit time) → DATA.
  - DATA (8 bits, LSB first, 1 bit time each) → STOP.
  - STOP (tx=1, 1 bit time) → START if more bytes of the current message remain.
  - STOP → START with an immediate pop if the FIFO is non-empty.
  - STOP → IDLE otherwise.
- Byte order per message: status, data1, data2. There are no gaps between bytes or between back-to-back messages.
- Bit timer: counts 0..CLKS_PER_BIT-1 and advances the bit index on the terminal count. Width is clog2(CLKS_PER_BIT).
- The FIFO uses wrap-around pointers with an extra MSB to distinguish full from empty. Count range is 0..2^N.
- `busy` = (FIFO count ≠ 0) | (state ≠ IDLE).
- Message contents are not validated. Bytes are sent as given.

## Timing
- `input_valid` in cycle N with an empty FIFO in IDLE:
  - write at the end of N;
  - pop at the end of N+1;
  - `tx`=0 (start bit) from cycle N+2.
- `busy` rises in cycle N+1.
- Each bit lasts exactly CLKS_PER_BIT cycles.
- A full message lasts 30·CLKS_PER_BIT cycles, or 20·CLKS_PER_BIT when the status byte is suppressed.
- `busy` falls in the first cycle after the final stop bit completes, when no message is pending.
- `tx` is a registered output and glitch-free.

## Configuration
- `MIDI_RUNNING_STATUS_EN` defined:
  - A register holds the last transmitted status byte plus a valid bit.
  - At pop, if the valid bit is set and the status equals the stored status, the status byte is skipped and transmission starts at data1.
  - Otherwise the status byte is sent and stored, and the valid bit is set.
  - Only reset clears the valid bit.
- `MIDI_RUNNING_STATUS_EN` undefined: every message sends all 3 bytes, and no status register exists.

## Test plan
- Single message, CLKS_PER_BIT=4, `midi_in`=0x403C90:
  - `tx` low from N+2.
  - Bytes decode as 0x90, 0x3C, 0x40, each framed start=0 / stop=1.
  - Total 120 cycles.
  - `busy` falls on cycle 121 after the start bit.
- Overflow, FIFO_DEPTH_LOG2=1: 4 valid pulses on consecutive cycles (0x403C90, 0x403E90, 0x404090, 0x404190).
  - First is popped; second and third are buffered; fourth is dropped.
  - `overflow`=1 and stays set.
  - Exactly 3 messages go out back-to-back with no idle bits.
- Simultaneous push and pop while full: push is dropped and `overflow` sets; the popped message still transmits.
- Reset asserted mid-DATA of byte 2:
  - `tx`=1, `busy`=0, `overflow`=0 the next cycle.
  - A following message 0x004580 transmits completely (3 bytes).
- Running status enabled: send 0x403C90 then 0x403E90.
  - Second message is 20 bit-times: 0x3E, 0x40 only.
  - Then send 0x003C80: status 0x80 is sent.
- Running status disabled: the same sequence sends all 9 bytes.
